// File: rtl/voice_pkg.sv
// Shared types for the polyphonic voice allocator.
package voice_pkg;

    localparam int NOTE_W = 7;

    // Per-voice lifecycle; gate is high only in V_HELD.
    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_RETRIG  = 2'd1,
        V_HELD    = 2'd2,
        V_RELEASE = 2'd3
    } vstate_e;

    // Note event as seen by the allocator after on/off arbitration.
    typedef struct packed {
        logic              on;
        logic              off;
        logic [NOTE_W-1:0] note;
    } note_ev_t;

    // Voice index width; at least one bit.
    function automatic int vw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice: lifecycle state, latched note, and release-tail counter.
module voice_slot
    import voice_pkg::*;
#(
    parameter  int REL_TICKS = 4800,
    localparam int CW        = $clog2(REL_TICKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic [NOTE_W-1:0] alloc_note,
    input  logic              off_match,
    input  logic              low_strobe,
    output vstate_e           state,
    output logic [NOTE_W-1:0] note,
    output logic              gate
);

    localparam logic [CW-1:0] LAST = CW'(REL_TICKS - 1);

    logic [CW-1:0] rel_cnt;

    // Voice FSM; gate is registered alongside the state so it equals (state == V_HELD).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= V_IDLE;
            note    <= '0;
            rel_cnt <= '0;
            gate    <= 1'b0;
        end else if (alloc) begin
            // Allocation beats note_off and strobes in the same cycle.
            note    <= alloc_note;
            rel_cnt <= '0;
            if (state == V_HELD || state == V_RETRIG) begin
                // Drop the gate for one clk so the envelope sees a new rising edge.
                state <= V_RETRIG;
                gate  <= 1'b0;
            end else begin
                state <= V_HELD;
                gate  <= 1'b1;
            end
        end else begin
            case (state)
                V_RETRIG: begin
                    if (off_match) begin
                        state   <= V_RELEASE;
                        rel_cnt <= '0;
                        gate    <= 1'b0;
                    end else begin
                        state <= V_HELD;
                        gate  <= 1'b1;
                    end
                end
                V_HELD: begin
                    if (off_match) begin
                        state   <= V_RELEASE;
                        rel_cnt <= '0;
                        gate    <= 1'b0;
                    end
                end
                V_RELEASE: begin
                    if (low_strobe) begin
                        if (rel_cnt == LAST) begin
                            state   <= V_IDLE;
                            rel_cnt <= '0;
                        end else begin
                            rel_cnt <= rel_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note events onto NUM_VOICES adsr gates,
// stealing the least-recently-allocated voice when none is free.
module voice_alloc
    import voice_pkg::*;
#(
    parameter  int NUM_VOICES = 4,
    parameter  int REL_TICKS  = 4800,
    localparam int VW         = vw_of(NUM_VOICES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         low_strobe,
    input  logic                         note_on,
    input  logic                         note_off,
    input  logic [NOTE_W-1:0]            note,
    output logic [NUM_VOICES-1:0]        gate,
    output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic                         ev_valid,
    output logic [VW-1:0]                ev_voice,
    output logic                         ev_steal
);

    note_ev_t                              ev;
    vstate_e                               vst      [NUM_VOICES];
    logic     [NUM_VOICES-1:0][NOTE_W-1:0] vnote;
    logic     [NUM_VOICES-1:0][VW-1:0]     rank;
    logic     [NUM_VOICES-1:0]             alloc;
    logic     [NUM_VOICES-1:0]             off_match;

    logic          hit_ok, idle_ok, rel_ok, hld_ok;
    logic [VW-1:0] hit_sel, idle_sel, rel_sel, hld_sel;
    logic [VW-1:0] rel_rank, hld_rank;
    logic [VW-1:0] sel, old_rank;
    logic          sel_ok, steal;

    // note_on wins a same-cycle note_off.
    assign ev = '{on: note_on, off: note_off & ~note_on, note: note};

    // Packed voice-major layout puts voice i at bits [7i+6:7i].
    assign voice_note = vnote;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        assign alloc[i]     = ev.on && sel_ok && (sel == VW'(i));
        assign off_match[i] = ev.off && (vst[i] == V_HELD || vst[i] == V_RETRIG)
                              && (vnote[i] == ev.note);

        voice_slot #(.REL_TICKS(REL_TICKS)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .alloc      (alloc[i]),
            .alloc_note (ev.note),
            .off_match  (off_match[i]),
            .low_strobe (low_strobe),
            .state      (vst[i]),
            .note       (vnote[i]),
            .gate       (gate[i])
        );
    end

    // Priority voice selection: retrigger, lowest idle, oldest release, oldest held.
    always_comb begin
        hit_ok   = 1'b0;  hit_sel  = '0;
        idle_ok  = 1'b0;  idle_sel = '0;
        rel_ok   = 1'b0;  rel_sel  = '0;  rel_rank = '0;
        hld_ok   = 1'b0;  hld_sel  = '0;  hld_rank = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!hit_ok && vst[i] != V_IDLE && vnote[i] == ev.note) begin
                hit_ok  = 1'b1;
                hit_sel = VW'(i);
            end
            if (!idle_ok && vst[i] == V_IDLE) begin
                idle_ok  = 1'b1;
                idle_sel = VW'(i);
            end
            if (vst[i] == V_RELEASE && (!rel_ok || rank[i] < rel_rank)) begin
                rel_ok   = 1'b1;
                rel_rank = rank[i];
                rel_sel  = VW'(i);
            end
            // A RETRIG voice always carries the top rank, so including it never
            // changes the pick; it only guarantees a candidate always exists.
            if ((vst[i] == V_HELD || vst[i] == V_RETRIG) && (!hld_ok || rank[i] < hld_rank)) begin
                hld_ok   = 1'b1;
                hld_rank = rank[i];
                hld_sel  = VW'(i);
            end
        end

        sel    = '0;
        sel_ok = 1'b0;
        steal  = 1'b0;
        if (hit_ok) begin
            sel    = hit_sel;
            sel_ok = 1'b1;
        end else if (idle_ok) begin
            sel    = idle_sel;
            sel_ok = 1'b1;
        end else if (rel_ok) begin
            sel    = rel_sel;
            sel_ok = 1'b1;
            steal  = 1'b1;
        end else if (hld_ok) begin
            sel    = hld_sel;
            sel_ok = 1'b1;
            steal  = 1'b1;
        end
    end

    // Rank the chosen voice had before this allocation.
    always_comb begin
        old_rank = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (alloc[i]) old_rank = rank[i];
        end
    end

    // Age ranking: the allocated voice becomes youngest, younger ones shift down.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VOICES; i++) rank[i] <= VW'(i);
        end else if (ev.on && sel_ok) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (alloc[i])
                    rank[i] <= VW'(NUM_VOICES - 1);
                else if (rank[i] > old_rank)
                    rank[i] <= rank[i] - 1'b1;
            end
        end
    end

    // Allocation event report, one pulse per note_on.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ev_valid <= 1'b0;
            ev_voice <= '0;
            ev_steal <= 1'b0;
        end else begin
            ev_valid <= ev.on && sel_ok;
            ev_steal <= ev.on && sel_ok && steal;
            if (ev.on && sel_ok) ev_voice <= sel;
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: directed scenarios plus random traffic against an
// age-queue reference model.
module tb_voice_alloc;

    localparam int NV  = 4;
    localparam int REL = 4;
    localparam int MI = 0, MR = 1, MH = 2, MRL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          low_strobe = 1'b0;
    logic          note_on = 1'b0;
    logic          note_off = 1'b0;
    logic [6:0]    note = '0;
    logic [NV-1:0] gate;
    logic [7*NV-1:0] voice_note;
    logic          ev_valid;
    logic [1:0]    ev_voice;
    logic          ev_steal;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state, note, release count per voice, and an age queue (oldest first).
    int mst  [NV];
    int mnote[NV];
    int mcnt [NV];
    int mq   [$];
    bit m_ev;
    int m_evv;
    bit m_stl;

    voice_alloc #(.NUM_VOICES(NV), .REL_TICKS(REL)) dut (
        .clk        (clk),
        .rst        (rst),
        .low_strobe (low_strobe),
        .note_on    (note_on),
        .note_off   (note_off),
        .note       (note),
        .gate       (gate),
        .voice_note (voice_note),
        .ev_valid   (ev_valid),
        .ev_voice   (ev_voice),
        .ev_steal   (ev_steal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit on, input bit off, input int n, input bit stb, input bit r);
        int ch;
        int idx;
        ch = -1;
        if (!r) begin
            for (int v = 0; v < NV; v++) begin
                mst[v] = MI; mnote[v] = 0; mcnt[v] = 0;
            end
            mq.delete();
            for (int v = 0; v < NV; v++) mq.push_back(v);
            m_ev = 0; m_evv = 0; m_stl = 0;
            return;
        end
        if (on) begin
            for (int v = 0; v < NV; v++)
                if (ch < 0 && mst[v] != MI && mnote[v] == n) ch = v;
            for (int v = 0; v < NV; v++)
                if (ch < 0 && mst[v] == MI) ch = v;
            foreach (mq[k])
                if (ch < 0 && mst[mq[k]] == MRL) ch = mq[k];
            foreach (mq[k])
                if (ch < 0 && mst[mq[k]] == MH) ch = mq[k];
            m_stl = (mst[ch] == MH || mst[ch] == MRL) && mnote[ch] != n;
            m_evv = ch;
        end
        m_ev = on;
        for (int v = 0; v < NV; v++) begin
            if (on && v == ch) begin
                mst[v]   = (mst[v] == MH || mst[v] == MR) ? MR : MH;
                mnote[v] = n;
                mcnt[v]  = 0;
            end else if (!on && off && (mst[v] == MH || mst[v] == MR) && mnote[v] == n) begin
                mst[v]  = MRL;
                mcnt[v] = 0;
            end else if (mst[v] == MR) begin
                mst[v] = MH;
            end else if (mst[v] == MRL && stb) begin
                if (mcnt[v] == REL - 1) mst[v] = MI;
                else mcnt[v]++;
            end
        end
        if (on) begin
            idx = -1;
            foreach (mq[k]) if (mq[k] == ch) idx = k;
            mq.delete(idx);
            mq.push_back(ch);
        end
    endtask

    task automatic compare_model();
        logic [NV-1:0]   eg;
        logic [7*NV-1:0] evn;
        for (int v = 0; v < NV; v++) begin
            eg[v] = (mst[v] == MH);
            evn[7*v +: 7] = 7'(mnote[v]);
        end
        check("gate", 32'(gate), 32'(eg));
        check("voice_note", 32'(voice_note), 32'(evn));
        check("ev_valid", 32'(ev_valid), 32'(m_ev));
        if (m_ev) begin
            check("ev_voice", 32'(ev_voice), 32'(m_evv));
            check("ev_steal", 32'(ev_steal), 32'(m_stl));
        end
    endtask

    // Drive one clock of inputs, advance the model, and compare after the edge.
    task automatic step(input bit on, input bit off, input int n, input bit stb, input bit r);
        @(negedge clk);
        rst = r; note_on = on; note_off = off; note = 7'(n); low_strobe = stb;
        @(posedge clk);
        #1;
        model_step(on, off, n, stb, r);
        compare_model();
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_gate", 32'(gate), 0);
        check("rst_vnote", 32'(voice_note), 0);
        check("rst_ev_valid", 32'(ev_valid), 0);
        check("rst_ev_voice", 32'(ev_voice), 0);
        check("rst_ev_steal", 32'(ev_steal), 0);

        // First allocation
        step(1, 0, 60, 0, 1);
        check("on60_gate", 32'(gate), 32'h1);
        check("on60_note", 32'(voice_note[6:0]), 60);
        check("on60_ev_valid", 32'(ev_valid), 1);
        check("on60_ev_voice", 32'(ev_voice), 0);
        check("on60_ev_steal", 32'(ev_steal), 0);

        // Fill remaining voices back to back, then steal the oldest held
        step(1, 0, 62, 0, 1);
        step(1, 0, 64, 0, 1);
        step(1, 0, 67, 0, 1);
        check("full_gate", 32'(gate), 32'hF);
        step(1, 0, 69, 0, 1);
        check("steal_gate0_lo", 32'(gate[0]), 0);
        check("steal_note", 32'(voice_note[6:0]), 69);
        check("steal_ev_voice", 32'(ev_voice), 0);
        check("steal_ev_steal", 32'(ev_steal), 1);
        step(0, 0, 0, 0, 1);
        check("steal_gate0_hi", 32'(gate[0]), 1);

        // Released voice is preferred over older held voices
        step(0, 1, 62, 0, 1);
        check("off62_gate", 32'(gate), 32'hD);
        step(1, 0, 72, 0, 1);
        check("rel_pick_voice", 32'(ev_voice), 1);
        check("rel_pick_gate1", 32'(gate[1]), 1);
        check("rel_pick_steal", 32'(ev_steal), 1);
        check("rel_pick_note", 32'(voice_note[13:7]), 72);

        // Release tail expires after REL_TICKS strobes, then voice 0 is free
        step(0, 1, 69, 0, 1);
        check("off69_gate0", 32'(gate[0]), 0);
        for (int k = 0; k < 45; k++) step(0, 0, 0, (k % 10) == 9, 1);
        step(1, 0, 50, 0, 1);
        check("idle_pick_voice", 32'(ev_voice), 0);
        check("idle_pick_steal", 32'(ev_steal), 0);
        check("idle_pick_gate", 32'(gate), 32'hF);

        // Simultaneous on/off of a held note retriggers it
        step(1, 1, 50, 0, 1);
        check("simul_gate0_lo", 32'(gate[0]), 0);
        check("simul_ev_voice", 32'(ev_voice), 0);
        check("simul_ev_steal", 32'(ev_steal), 0);
        step(0, 0, 0, 0, 1);
        check("simul_gate0_hi", 32'(gate[0]), 1);

        // Reset during RETRIG clears everything and restores rank order
        step(1, 0, 72, 0, 1);
        check("retrig_ev_voice", 32'(ev_voice), 1);
        check("retrig_gate1_lo", 32'(gate[1]), 0);
        step(0, 0, 0, 0, 0);
        check("midrst_gate", 32'(gate), 0);
        check("midrst_vnote", 32'(voice_note), 0);
        check("midrst_ev_valid", 32'(ev_valid), 0);
        check("midrst_ev_voice", 32'(ev_voice), 0);
        for (int k = 0; k < 4; k++) step(1, 0, 10 + k, 0, 1);
        step(1, 0, 14, 0, 1);
        check("rank_steal0", 32'(ev_voice), 0);
        step(1, 0, 15, 0, 1);
        check("rank_steal1", 32'(ev_voice), 1);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(3) == 0, $urandom_range(3) == 0, 60 + $urandom_range(7),
                 $urandom_range(3) == 0, $urandom_range(499) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
